// File: rtl/cpu_debug_controller_if.sv
// Run-control / observation bundle between the board I/O layer and cpu_debug_controller.
// Latency: none (wires only); all controller outputs on it are registered inside the controller.
// Backpressure: none; requests are single-cycle pulses, status outputs are levels.
// Ports: master drives requests, breakpoint setup and core observations (pc_in, instr_retire, flags_in);
//        slave (the controller) drives cpu_en, halted, bp_hit, bp_idx, flags_snap and both counters.
interface cpu_debug_controller_if #(
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32,
  parameter int STEP_W = 8,
  parameter int NUM_BP = 2
);
  logic                   run_req;
  logic                   halt_req;
  logic                   step_req;
  logic [STEP_W-1:0]      step_count;
  logic [NUM_BP-1:0]      bp_en;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [PC_W-1:0]        pc_in;
  logic                   instr_retire;
  logic [3:0]             flags_in;

  logic                   cpu_en;
  logic                   halted;
  logic                   bp_hit;
  logic [2:0]             bp_idx;
  logic [3:0]             flags_snap;
  logic [CNT_W-1:0]       cycle_count;
  logic [CNT_W-1:0]       retire_count;

  modport master (
    output run_req, halt_req, step_req, step_count, bp_en, bp_addr,
           pc_in, instr_retire, flags_in,
    input  cpu_en, halted, bp_hit, bp_idx, flags_snap, cycle_count, retire_count
  );

  modport slave (
    input  run_req, halt_req, step_req, step_count, bp_en, bp_addr,
           pc_in, instr_retire, flags_in,
    output cpu_en, halted, bp_hit, bp_idx, flags_snap, cycle_count, retire_count
  );
endinterface

// File: rtl/cpu_debug_controller.sv
// Core run-control: gates cpu_en for run / halt / N-unit step / PC breakpoint, keeps cycle and retire counters.
// Latency: one cycle from request or breakpoint match to cpu_en/halted change; all outputs registered.
// Backpressure: none; requests not applicable to the current state are dropped (halt > step > run).
// Ports: clk, rst_n (async active-low), dbg (cpu_debug_controller_if.slave).
// Optional: define DEBUG_RETIRE_STEP_EN to make a step count retired instructions instead of cycles.
module cpu_debug_controller #(
  parameter int PC_W      = 32,
  parameter int CNT_W     = 32,
  parameter int STEP_W    = 8,
  parameter int NUM_BP    = 2,
  parameter bit RESET_RUN = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  cpu_debug_controller_if.slave dbg
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_BREAK = 2'd3;
  localparam logic [1:0] S_RESET = RESET_RUN ? S_RUN : S_HALT;

  logic [1:0]        r_state;
  logic [STEP_W-1:0] r_rem;
  logic              r_cpu_en;
  logic              r_halted;
  logic              r_bp_hit;
  logic [2:0]        r_bp_idx;
  logic [3:0]        r_flags;
  logic [CNT_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_ret;
  logic [PC_W-1:0]   r_brk_pc;
  logic              r_mask_vld;
  logic [2:0]        r_mask_idx;
  logic [PC_W-1:0]   r_mask_pc;

  logic [NUM_BP-1:0] w_match;
  logic              w_any;
  logic [2:0]        w_hit_idx;
  logic [STEP_W-1:0] w_step_load;
  logic              w_step_tick;
  logic [1:0]        w_next;
  logic [STEP_W-1:0] w_rem_nxt;
  logic              w_halt_in;
  logic              w_brk_in;
  logic              w_resume;

  // The comparator that caused the last break stays suppressed while the PC
  // still sits on the break address, so resuming never re-hits at once.
  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      w_match[i] = dbg.bp_en[i] && (dbg.pc_in == dbg.bp_addr[i*PC_W +: PC_W]) &&
                   !(r_mask_vld && (r_mask_idx == 3'(i)) && (dbg.pc_in == r_mask_pc));
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_idx = 3'(i);
    end
  end

  assign w_any       = |w_match;
  assign w_step_load = (dbg.step_count == '0) ? STEP_W'(1) : dbg.step_count;

`ifdef DEBUG_RETIRE_STEP_EN
  assign w_step_tick = dbg.instr_retire;
`else
  assign w_step_tick = 1'b1;
`endif

  always_comb begin
    w_next    = r_state;
    w_rem_nxt = r_rem;
    w_halt_in = 1'b0;
    w_brk_in  = 1'b0;
    w_resume  = 1'b0;
    case (r_state)
      S_RUN, S_STEP: begin
        if (dbg.halt_req) begin
          w_next    = S_HALT;
          w_halt_in = 1'b1;
          w_rem_nxt = '0;
        end else if (w_any) begin
          w_next    = S_BREAK;
          w_brk_in  = 1'b1;
          w_rem_nxt = '0;
        end else if ((r_state == S_STEP) && w_step_tick) begin
          // Remainder of 1 at this edge means this was the last enabled unit.
          if (r_rem <= STEP_W'(1)) begin
            w_next    = S_HALT;
            w_halt_in = 1'b1;
            w_rem_nxt = '0;
          end else begin
            w_rem_nxt = r_rem - STEP_W'(1);
          end
        end
      end
      default: begin
        // HALT and BREAK: a simultaneous halt_req outranks and swallows step/run.
        if (!dbg.halt_req) begin
          if (dbg.step_req) begin
            w_next    = S_STEP;
            w_rem_nxt = w_step_load;
            w_resume  = 1'b1;
          end else if (dbg.run_req) begin
            w_next   = S_RUN;
            w_resume = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RESET;
      r_rem      <= '0;
      r_cpu_en   <= RESET_RUN;
      r_halted   <= !RESET_RUN;
      r_bp_hit   <= 1'b0;
      r_bp_idx   <= '0;
      r_flags    <= '0;
      r_cyc      <= '0;
      r_ret      <= '0;
      r_brk_pc   <= '0;
      r_mask_vld <= 1'b0;
      r_mask_idx <= '0;
      r_mask_pc  <= '0;
    end else begin
      r_state <= w_next;
      r_rem   <= w_rem_nxt;

      if (r_cpu_en) begin
        r_cyc <= r_cyc + CNT_W'(1);
        if (dbg.instr_retire) r_ret <= r_ret + CNT_W'(1);
      end

      if (w_halt_in || w_brk_in) begin
        r_cpu_en <= 1'b0;
        r_halted <= 1'b1;
        r_flags  <= dbg.flags_in;
      end
      if (w_brk_in) begin
        r_bp_hit <= 1'b1;
        r_bp_idx <= w_hit_idx;
        r_brk_pc <= dbg.pc_in;
      end
      if (w_resume) begin
        r_cpu_en <= 1'b1;
        r_halted <= 1'b0;
        r_bp_hit <= 1'b0;
      end

      // Mask release first; arming on exit from BREAK overrides it.
      if (r_mask_vld && (dbg.pc_in != r_mask_pc)) r_mask_vld <= 1'b0;
      if (w_resume && (r_state == S_BREAK)) begin
        r_mask_vld <= 1'b1;
        r_mask_idx <= r_bp_idx;
        r_mask_pc  <= r_brk_pc;
      end
    end
  end

  assign dbg.cpu_en       = r_cpu_en;
  assign dbg.halted       = r_halted;
  assign dbg.bp_hit       = r_bp_hit;
  assign dbg.bp_idx       = r_bp_idx;
  assign dbg.flags_snap   = r_flags;
  assign dbg.cycle_count  = r_cyc;
  assign dbg.retire_count = r_ret;

endmodule
